// File: rtl/switch_allocator_if.sv
// Request/grant bundle between router input buffers and the switch allocator.
// Handshake: request[p][v] is a level held by the input buffer; grant[p][v] is
// a same-cycle acknowledge, and the flit is dequeued on the edge where both are 1.
interface switch_allocator_if #(
  parameter int PORT_NUM = 5,
  parameter int VC_NUM   = 2
);
  localparam int PW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
  localparam int VW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

  logic [PORT_NUM-1:0][VC_NUM-1:0]         request;
  logic [PORT_NUM-1:0][VC_NUM-1:0][PW-1:0] out_port;
  logic [PORT_NUM-1:0]                     credit_ok;
  logic [PORT_NUM-1:0]                     valid_sel;
  logic [PORT_NUM-1:0][PW-1:0]             input_vc_sel;
  logic [PORT_NUM-1:0][VC_NUM-1:0]         grant;
  // Round-robin pointer state, exposed for observation only.
  logic [PORT_NUM-1:0][VW-1:0]             in_ptr_dbg;
  logic [PORT_NUM-1:0][PW-1:0]             out_ptr_dbg;

  modport master (
    output request, out_port, credit_ok,
    input  valid_sel, input_vc_sel, grant, in_ptr_dbg, out_ptr_dbg
  );

  modport slave (
    input  request, out_port, credit_ok,
    output valid_sel, input_vc_sel, grant, in_ptr_dbg, out_ptr_dbg
  );
endinterface

// File: rtl/switch_allocator.sv
// Separable input-first switch allocator: per-input VC round-robin, then
// per-output input-port round-robin, all combinational; only pointers are state.
module switch_allocator #(
  parameter int PORT_NUM = 5,
  parameter int VC_NUM   = 2
) (
  input  logic           clk,
  input  logic           rst,
  switch_allocator_if.slave sa
);
  localparam int PW  = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
  localparam int VW  = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int PN2 = 1 << PW;

  logic [PORT_NUM-1:0][VW-1:0]     in_ptr;
  logic [PORT_NUM-1:0][PW-1:0]     out_ptr;
  logic [PN2-1:0]                  credit_pad;
  logic [PORT_NUM-1:0][VC_NUM-1:0] eligible;
  logic [PORT_NUM-1:0]             s1_valid;
  logic [PORT_NUM-1:0][VW-1:0]     s1_vc;
  logic [PORT_NUM-1:0][PW-1:0]     s1_out;
  logic [PORT_NUM-1:0][VC_NUM-1:0] grant_int;
  logic [PORT_NUM-1:0]             valid_int;
  logic [PORT_NUM-1:0][PW-1:0]     sel_int;

  // Pad credits to the full index range so out-of-range out_port values read 0.
  always_comb begin
    credit_pad = '0;
    credit_pad[PORT_NUM-1:0] = sa.credit_ok;
    for (int p = 0; p < PORT_NUM; p++)
      for (int v = 0; v < VC_NUM; v++)
        eligible[p][v] = sa.request[p][v]
                         && (int'(sa.out_port[p][v]) < PORT_NUM)
                         && credit_pad[sa.out_port[p][v]];
  end

  always_comb begin
    int v;
    v        = 0;
    s1_valid = '0;
    s1_vc    = '0;
    s1_out   = '0;
    for (int p = 0; p < PORT_NUM; p++)
      for (int k = 0; k < VC_NUM; k++) begin
        v = (int'(in_ptr[p]) + k) % VC_NUM;
        if (!s1_valid[p] && eligible[p][v]) begin
          s1_valid[p] = 1'b1;
          s1_vc[p]    = VW'(v);
          s1_out[p]   = sa.out_port[p][v];
        end
      end
  end

  // Stage-1 winners that lose here simply get no grant this cycle.
  always_comb begin
    int p;
    p         = 0;
    grant_int = '0;
    valid_int = '0;
    sel_int   = '0;
    for (int o = 0; o < PORT_NUM; o++)
      for (int k = 0; k < PORT_NUM; k++) begin
        p = (int'(out_ptr[o]) + k) % PORT_NUM;
        if (!valid_int[o] && s1_valid[p] && (s1_out[p] == PW'(o))) begin
          valid_int[o]          = 1'b1;
          sel_int[o]            = PW'(p);
          grant_int[p][s1_vc[p]] = 1'b1;
        end
      end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ptr  <= '0;
      out_ptr <= '0;
    end else begin
      for (int p = 0; p < PORT_NUM; p++)
        if (|grant_int[p])
          in_ptr[p] <= VW'((int'(s1_vc[p]) + 1) % VC_NUM);
      for (int o = 0; o < PORT_NUM; o++)
        if (valid_int[o])
          out_ptr[o] <= PW'((int'(sel_int[o]) + 1) % PORT_NUM);
    end
  end

  // Outputs are forced low for as long as reset is held, independent of inputs.
  assign sa.grant        = rst ? grant_int : '0;
  assign sa.valid_sel    = rst ? valid_int : '0;
  assign sa.input_vc_sel = rst ? sel_int   : '0;
  assign sa.in_ptr_dbg   = in_ptr;
  assign sa.out_ptr_dbg  = out_ptr;
endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator with 5 ports and 2 VCs.
module tb_switch_allocator;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  switch_allocator_if #(.PORT_NUM(5), .VC_NUM(2)) sa_if ();

  switch_allocator #(.PORT_NUM(5), .VC_NUM(2)) dut (
    .clk (clk),
    .rst (rst),
    .sa  (sa_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    sa_if.request   = '0;
    sa_if.out_port  = '0;
    sa_if.credit_ok = 5'b11111;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    sa_if.request   = '1;
    sa_if.out_port  = '0;
    sa_if.credit_ok = 5'b11111;
    #2;
    checks++;
    if (sa_if.grant !== 10'd0) begin
      errors++; $display("FAIL reset_grant: got %h expected 0", sa_if.grant);
    end
    checks++;
    if (sa_if.valid_sel !== 5'd0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", sa_if.valid_sel);
    end
    checks++;
    if (sa_if.input_vc_sel !== 15'd0) begin
      errors++; $display("FAIL reset_sel: got %h expected 0", sa_if.input_vc_sel);
    end
    @(negedge clk);
    checks++;
    if (sa_if.in_ptr_dbg !== 5'd0 || sa_if.out_ptr_dbg !== 15'd0) begin
      errors++; $display("FAIL reset_ptrs: got in %h out %h expected 0 0",
                         sa_if.in_ptr_dbg, sa_if.out_ptr_dbg);
    end
    step();
    rst = 1'b1;
    clear_inputs();
  endtask

  task automatic test_single();
    logic [4:0][1:0] exp_g;
    do_reset();
    sa_if.request[1][0]  = 1'b1;
    sa_if.out_port[1][0] = 3'd4;
    exp_g = '0;
    exp_g[1][0] = 1'b1;
    @(negedge clk);
    checks++;
    if (sa_if.grant !== exp_g) begin
      errors++; $display("FAIL single_grant: got %h expected %h", sa_if.grant, exp_g);
    end
    checks++;
    if (sa_if.valid_sel !== 5'b10000 || sa_if.input_vc_sel[4] !== 3'd1) begin
      errors++; $display("FAIL single_route: got valid %b sel4 %0d expected 10000 1",
                         sa_if.valid_sel, sa_if.input_vc_sel[4]);
    end
    step();
    clear_inputs();
    checks++;
    if (sa_if.in_ptr_dbg[1] !== 1'b1 || sa_if.out_ptr_dbg[4] !== 3'd2) begin
      errors++; $display("FAIL single_ptrs: got in1 %0d out4 %0d expected 1 2",
                         sa_if.in_ptr_dbg[1], sa_if.out_ptr_dbg[4]);
    end
  endtask

  task automatic test_output_rr();
    int exp_in[6] = '{0, 2, 3, 0, 2, 3};
    logic [4:0][1:0] exp_g;
    do_reset();
    sa_if.request[0][0] = 1'b1; sa_if.out_port[0][0] = 3'd1;
    sa_if.request[2][0] = 1'b1; sa_if.out_port[2][0] = 3'd1;
    sa_if.request[3][0] = 1'b1; sa_if.out_port[3][0] = 3'd1;
    for (int c = 0; c < 6; c++) begin
      exp_g = '0;
      exp_g[exp_in[c]][0] = 1'b1;
      @(negedge clk);
      checks++;
      if (sa_if.grant !== exp_g || sa_if.valid_sel !== 5'b00010
          || sa_if.input_vc_sel[1] !== 3'(exp_in[c])) begin
        errors++; $display("FAIL output_rr[%0d]: got grant %h valid %b sel1 %0d expected %h 00010 %0d",
                           c, sa_if.grant, sa_if.valid_sel, sa_if.input_vc_sel[1], exp_g, exp_in[c]);
      end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_vc_rr();
    logic [4:0][1:0] exp_g;
    do_reset();
    sa_if.request[2]     = 2'b11;
    sa_if.out_port[2][0] = 3'd3;
    sa_if.out_port[2][1] = 3'd3;
    for (int c = 0; c < 4; c++) begin
      exp_g = '0;
      exp_g[2][c % 2] = 1'b1;
      @(negedge clk);
      checks++;
      if (sa_if.grant !== exp_g || sa_if.input_vc_sel[3] !== 3'd2) begin
        errors++; $display("FAIL vc_rr[%0d]: got grant %h sel3 %0d expected %h 2",
                           c, sa_if.grant, sa_if.input_vc_sel[3], exp_g);
      end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_credit();
    logic [4:0][1:0] exp_g;
    do_reset();
    sa_if.request[0][0] = 1'b1; sa_if.out_port[0][0] = 3'd2;
    sa_if.request[1][0] = 1'b1; sa_if.out_port[1][0] = 3'd2;
    sa_if.credit_ok = 5'b11011;
    @(negedge clk);
    checks++;
    if (sa_if.grant !== 10'd0 || sa_if.valid_sel !== 5'd0) begin
      errors++; $display("FAIL credit_block: got grant %h valid %b expected 0 0",
                         sa_if.grant, sa_if.valid_sel);
    end
    step();
    checks++;
    if (sa_if.in_ptr_dbg !== 5'd0 || sa_if.out_ptr_dbg !== 15'd0) begin
      errors++; $display("FAIL credit_ptrs: got in %h out %h expected 0 0",
                         sa_if.in_ptr_dbg, sa_if.out_ptr_dbg);
    end
    sa_if.credit_ok = 5'b11111;
    exp_g = '0;
    exp_g[0][0] = 1'b1;
    @(negedge clk);
    checks++;
    if (sa_if.grant !== exp_g || sa_if.valid_sel !== 5'b00100 || sa_if.input_vc_sel[2] !== 3'd0) begin
      errors++; $display("FAIL credit_release: got grant %h valid %b sel2 %0d expected %h 00100 0",
                         sa_if.grant, sa_if.valid_sel, sa_if.input_vc_sel[2], exp_g);
    end
    step();
    clear_inputs();
  endtask

  task automatic drive_permutation();
    for (int p = 0; p < 5; p++) begin
      sa_if.request[p][0]  = 1'b1;
      sa_if.out_port[p][0] = 3'(4 - p);
    end
  endtask

  task automatic test_permutation();
    logic [4:0][1:0] exp_g;
    logic [4:0][2:0] exp_sel;
    logic [4:0][2:0] exp_optr;
    exp_g    = 10'b01_01_01_01_01;
    exp_sel  = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    exp_optr = {3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    do_reset();
    drive_permutation();
    @(negedge clk);
    checks++;
    if (sa_if.grant !== exp_g || sa_if.valid_sel !== 5'b11111) begin
      errors++; $display("FAIL perm_grant: got grant %h valid %b expected %h 11111",
                         sa_if.grant, sa_if.valid_sel, exp_g);
    end
    checks++;
    if (sa_if.input_vc_sel !== exp_sel) begin
      errors++; $display("FAIL perm_sel: got %h expected %h", sa_if.input_vc_sel, exp_sel);
    end
    step();
    clear_inputs();
    checks++;
    if (sa_if.in_ptr_dbg !== 5'b11111 || sa_if.out_ptr_dbg !== exp_optr) begin
      errors++; $display("FAIL perm_ptrs: got in %b out %h expected 11111 %h",
                         sa_if.in_ptr_dbg, sa_if.out_ptr_dbg, exp_optr);
    end
  endtask

  task automatic test_uturn_invalid();
    logic [4:0][1:0] exp_g;
    do_reset();
    sa_if.request[3]     = 2'b11;
    sa_if.out_port[3][0] = 3'd3;
    sa_if.out_port[3][1] = 3'd5;
    exp_g = '0;
    exp_g[3][0] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (sa_if.grant !== exp_g || sa_if.valid_sel !== 5'b01000 || sa_if.input_vc_sel[3] !== 3'd3) begin
        errors++; $display("FAIL uturn[%0d]: got grant %h valid %b sel3 %0d expected %h 01000 3",
                           c, sa_if.grant, sa_if.valid_sel, sa_if.input_vc_sel[3], exp_g);
      end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_async_reset();
    logic [4:0][1:0] exp_g;
    exp_g = 10'b01_01_01_01_01;
    do_reset();
    drive_permutation();
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (sa_if.grant !== 10'd0 || sa_if.valid_sel !== 5'd0 || sa_if.input_vc_sel !== 15'd0) begin
      errors++; $display("FAIL async_outputs: got grant %h valid %b sel %h expected 0 0 0",
                         sa_if.grant, sa_if.valid_sel, sa_if.input_vc_sel);
    end
    checks++;
    if (sa_if.in_ptr_dbg !== 5'd0 || sa_if.out_ptr_dbg !== 15'd0) begin
      errors++; $display("FAIL async_ptrs: got in %h out %h expected 0 0",
                         sa_if.in_ptr_dbg, sa_if.out_ptr_dbg);
    end
    step();
    rst = 1'b1;
    #1;
    checks++;
    if (sa_if.grant !== exp_g || sa_if.in_ptr_dbg !== 5'd0 || sa_if.out_ptr_dbg !== 15'd0) begin
      errors++; $display("FAIL async_release: got grant %h in %h out %h expected %h 0 0",
                         sa_if.grant, sa_if.in_ptr_dbg, sa_if.out_ptr_dbg, exp_g);
    end
    step();
    clear_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    clear_inputs();
    test_reset();
    test_single();
    test_output_rr();
    test_vc_rr();
    test_credit();
    test_permutation();
    test_uturn_invalid();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/switch_allocator.md
SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

Interface
REQ-001 Parameter PORT_NUM, default 5, number of router input and output ports (0=LOCAL,1=NORTH,2=SOUTH,3=WEST,4=EAST).
REQ-002 Parameter VC_NUM, default 2, virtual channels per input port.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low.
REQ-005 request  input  [PORT_NUM][VC_NUM]  input VC v of port p holds a flit ready for switch traversal.
REQ-006 out_port  input  [PORT_NUM][VC_NUM] x $clog2(PORT_NUM)  requested output port of each input VC.
REQ-007 credit_ok  input  [PORT_NUM]  downstream of output o has at least one free buffer slot.
REQ-008 valid_sel  output  [PORT_NUM]  output o carries a flit this cycle.
REQ-009 input_vc_sel  output  [PORT_NUM] x $clog2(PORT_NUM)  input port index routed to output o; consumed by the crossbar.
REQ-010 grant  output  [PORT_NUM][VC_NUM]  one-hot per input port; input VC v of port p is dequeued this cycle.

Function
REQ-011 Allocation SHALL be separable input-first, combinational, same-cycle: grant, valid_sel, input_vc_sel derive from current inputs and current pointer state.
REQ-012 Eligibility: VC (p,v) eligible iff request[p][v]=1, credit_ok[out_port[p][v]]=1 and out_port[p][v] < PORT_NUM.
REQ-013 Stage 1: per input p, a round-robin arbiter over eligible VCs picks one winner, starting search at in_ptr[p] and wrapping VC_NUM-1 -> 0.
REQ-014 Stage 2: per output o, a round-robin arbiter over input ports whose stage-1 winner targets o picks one, starting at out_ptr[o], wrapping PORT_NUM-1 -> 0.
REQ-015 grant[p][v]=1 only if (p,v) wins both stages; at most one grant per input port and at most one per output port per cycle.
REQ-016 valid_sel[o]=1 iff output o granted some input; input_vc_sel[o] = that input index, else 0.
REQ-017 Stage-1 winners losing stage 2 receive no grant; no retry within the same cycle.
REQ-018 Pointer update on rising edge, only for granted arbiters: in_ptr[p] <= (granted v + 1) mod VC_NUM; out_ptr[o] <= (granted p + 1) mod PORT_NUM.
REQ-019 Arbiters without a grant in a cycle SHALL hold their pointer.
REQ-020 No requests or all credit_ok=0: all outputs 0, pointers unchanged.
REQ-021 Fairness: a continuously eligible VC SHALL be granted within PORT_NUM*VC_NUM cycles.
REQ-022 U-turns (out_port == own input port) SHALL be allocated as any other request; suppression is upstream responsibility.

Reset
REQ-023 While rst=0: all in_ptr and out_ptr = 0, grant = 0, valid_sel = 0, input_vc_sel = 0, regardless of inputs.
REQ-024 Reset asserted mid-operation clears pointers immediately; first cycle after deassertion arbitrates from index 0.
REQ-025 Flit or credit state SHALL NOT be held inside this block; only the round-robin pointers are state.

Verification
REQ-026 After reset, request[1][0]=1 out_port=4, credit_ok=all 1 -> grant[1][0]=1, valid_sel[4]=1, input_vc_sel[4]=1 same cycle; in_ptr[1]=1, out_ptr[4]=2 next cycle.
REQ-027 Inputs 0,2,3 VC0 all target output 1, held 6 cycles -> granted inputs 0,2,3,0,2,3; one grant per cycle; valid_sel[1]=1 throughout.
REQ-028 Input 2 VC0 and VC1 both target output 3 (both held) -> grants alternate VC0,VC1,VC0,VC1 on consecutive cycles.
REQ-029 Input 0 VC0->out 2, input 1 VC0->out 2, credit_ok[2]=0 -> no grants, valid_sel=0, pointers unchanged; credit_ok[2]=1 next cycle -> input 0 granted.
REQ-030 Five inputs each VC0 targeting distinct outputs (permutation 0->4,1->3,2->2,3->1,4->0) -> five grants same cycle, input_vc_sel = {4,3,2,1,0} for outputs 0..4.
REQ-031 rst pulled low asynchronously mid-cycle with grants active -> all outputs 0 before next edge; pointers 0 after release.
